// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default widths, instruction class encodings and the
// fetch FSM state type.
package cpu_pkg;

  localparam int unsigned CPU_ADDR_BITS   = 5;
  localparam int unsigned CPU_INSTR_WIDTH = 20;
  localparam int unsigned CPU_FETCH_DEPTH = 2;

  localparam logic [1:0] CLS_NOP   = 2'b00;
  localparam logic [1:0] CLS_STD   = 2'b01;
  localparam logic [1:0] CLS_LOAD  = 2'b10;
  localparam logic [1:0] CLS_STORE = 2'b11;

  localparam logic [CPU_INSTR_WIDTH-1:0] INSTR_RESET = '0;

  typedef enum logic {
    FETCH_IDLE,
    FETCH_WAIT
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {instr, pc} entries; flush empties it in one cycle and
// takes priority over a same-cycle push or pop.
module fetch_fifo #(
  parameter int unsigned WIDTH = 25,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]    count_q;

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, one-outstanding imem request FSM with credit
// check, redirect/drop handling, and prefetch FIFO feeding the control unit.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_BITS   = CPU_ADDR_BITS,
  parameter int unsigned INSTR_WIDTH = CPU_INSTR_WIDTH,
  parameter int unsigned DEPTH       = CPU_FETCH_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  output logic                   imem_req,
  output logic [ADDR_BITS-1:0]   imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   imem_valid,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic                   instr_valid,
  output logic [ADDR_BITS-1:0]   instr_pc,
  input  logic                   instr_ack,
  input  logic                   redirect,
  input  logic [ADDR_BITS-1:0]   redirect_addr
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned EW = INSTR_WIDTH + ADDR_BITS;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_state_t         state_q, state_d;
  logic [ADDR_BITS-1:0] pc_q, pc_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 drop_q, drop_d;
  logic [ADDR_BITS-1:0] last_pc_q;

  logic                   fifo_push, fifo_pop, fifo_empty;
  logic [CW-1:0]          fifo_count;
  logic [EW-1:0]          fifo_head;
  logic [INSTR_WIDTH-1:0] head_instr;
  logic [ADDR_BITS-1:0]   head_pc;

  // Redirect suppresses both ends of the FIFO; the flush alone decides its state.
  assign fifo_push = (state_q == FETCH_WAIT) && imem_valid && !drop_q && !redirect;
  assign fifo_pop  = instr_ack && !fifo_empty && !redirect;

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_ni  (rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .flush_i (redirect),
    .wdata_i ({imem_rdata, addr_q}),
    .rdata_o (fifo_head),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign {head_instr, head_pc} = fifo_head;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    drop_d  = drop_q;
    unique case (state_q)
      FETCH_IDLE: begin
        if (redirect) begin
          pc_d = redirect_addr;
        end else if (run && (fifo_count < DEPTH_C)) begin
          state_d = FETCH_WAIT;
          addr_d  = pc_q;
        end
      end
      FETCH_WAIT: begin
        if (imem_valid) begin
          state_d = FETCH_IDLE;
          drop_d  = 1'b0;
          if (redirect)     pc_d = redirect_addr;
          else if (!drop_q) pc_d = pc_q + 1'b1;
        end else if (redirect) begin
          // Response still in flight: mark it stale so it is neither pushed nor counted.
          drop_d = 1'b1;
          pc_d   = redirect_addr;
        end
      end
      default: state_d = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= FETCH_IDLE;
      pc_q      <= '0;
      addr_q    <= '0;
      drop_q    <= 1'b0;
      last_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      drop_q    <= drop_d;
      last_pc_q <= instr_pc;
    end
  end

  assign imem_req    = (state_q == FETCH_WAIT);
  assign imem_addr   = addr_q;
  assign instr_valid = !fifo_empty;
  assign instr       = fifo_empty ? INSTR_WIDTH'(INSTR_RESET) : head_instr;
  assign instr_pc    = fifo_empty ? last_pc_q : head_pc;

endmodule
